// File: rtl/led_pattern.sv
// led_pattern: an LED pattern generator with four modes (fill, bounce, blink,
// count). A debounced push button steps through the modes. A free-running
// tick counter paces the pattern, and the pause input freezes it.
module led_pattern #(
  parameter int NUM_LEDS        = 6,
  parameter int WAIT_TIME       = 13_500_000,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_n,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int TW = $clog2(WAIT_TIME);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TW-1:0]       TICK_LAST = TW'(WAIT_TIME - 1);
  localparam logic [DW-1:0]       DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_ALL   = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [DW-1:0]       db_cnt_q, db_cnt_d;
  logic                db_level_q, db_level_d;
  logic                press_q, press_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  mode_e               mode_q, mode_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                dir_up_q, dir_up_d;
  logic                tick_w;

  // A step is due when the counter sits at its last value and the pattern is not paused.
  assign tick_w = ~pause & (tick_cnt_q == TICK_LAST);

  // Button path: two-flop synchroniser, then a level debouncer. A press pulse is
  // raised only when the debounced level is accepted as going from 1 to 0.
  always_comb begin
    sync1_d    = btn_n;
    sync2_d    = sync1_q;
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
    press_d = db_level_q & ~db_level_d;
  end

  // Mode FSM and pattern datapath. A press beats a simultaneous tick: the new mode's
  // initial pattern is loaded and the tick counter restarts from zero.
  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    dir_up_d   = dir_up_q;
    tick_cnt_d = tick_cnt_q;
    if (press_q) begin
      mode_d     = mode_e'(mode_q + 2'd1);
      tick_cnt_d = '0;
      dir_up_d   = 1'b1;
      case (mode_d)
        MODE_FILL:   led_d = LED_ALL;
        MODE_BOUNCE: led_d = LED_ONE;
        MODE_BLINK:  led_d = LED_ALL;
        MODE_COUNT:  led_d = '0;
        default:     led_d = LED_ALL;
      endcase
    end else if (!pause) begin
      tick_cnt_d = tick_w ? '0 : tick_cnt_q + TW'(1);
      if (tick_w) begin
        case (mode_q)
          MODE_FILL: begin
            led_d = (led_q == '0) ? LED_ALL : (led_q << 1);
          end
          MODE_BOUNCE: begin
            // The direction flips when the hot bit arrives at an end, so each end is shown once.
            if (dir_up_q) begin
              led_d = led_q << 1;
              if (led_q[NUM_LEDS-2]) dir_up_d = 1'b0;
            end else begin
              led_d = led_q >> 1;
              if (led_q[1]) dir_up_d = 1'b1;
            end
          end
          MODE_BLINK: begin
            led_d = ~led_q;
          end
          MODE_COUNT: begin
            led_d = led_q + LED_ONE;
          end
          default: begin
            led_d = led_q;
          end
        endcase
      end
    end
  end

  // All state registers. Reset puts everything in the idle fill state with the button released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_cnt_q   <= '0;
      db_level_q <= 1'b1;
      press_q    <= 1'b0;
      tick_cnt_q <= '0;
      mode_q     <= MODE_FILL;
      led_q      <= LED_ALL;
      dir_up_q   <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      press_q    <= press_d;
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_up_q   <= dir_up_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_led_pattern.sv
// tb_led_pattern: self-checking bench for led_pattern with NUM_LEDS=4, WAIT_TIME=4,
// DEBOUNCE_CYCLES=3. Expected pattern values are queued ahead of time and popped
// one per tick. Pause behaviour is checked from a vector table. Press/tick
// collision and reset are checked by hand-written sequences.
module tb_led_pattern;
  localparam int NL = 4;
  localparam int WT = 4;
  localparam int DB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_n;
  logic          pause;
  logic [NL-1:0] led;
  logic [1:0]    mode;
  logic          tick;

  led_pattern #(.NUM_LEDS(NL), .WAIT_TIME(WT), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .pause(pause),
    .led(led), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] led;
    logic [1:0]    mode;
  } exp_t;

  typedef struct {
    logic          pause;
    logic          btn_n;
    logic [NL-1:0] exp_led;
    logic [1:0]    exp_mode;
    logic          exp_tick;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  int   n_checks  = 0;
  int   n_pass    = 0;
  bit   sb_en     = 1'b0;
  bit   pend      = 1'b0;
  int   cyc       = 0;
  int   last_tick = -1;
  logic tick_neg  = 1'b0;
  int   lat       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired or queue empty", name);
  endtask

  task automatic push_exp(input logic [NL-1:0] l, input logic [1:0] m);
    exp_t e;
    e.led  = l;
    e.mode = m;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      done = (sb_q.size() == 0);
    end
    if (!done) begin
      fail_now("sb_drain");
      sb_q.delete();
    end
  endtask

  // Press the button from a negedge, wait for the expected mode, then hold for 10 cycles and release.
  task automatic do_press(input logic [1:0] exp_mode, input logic [NL-1:0] exp_led,
                          input bit sb_after, output int latency);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    btn_n = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = (mode == exp_mode);
    end
    latency = n;
    if (!seen) begin
      fail_now("press_mode_change");
    end else begin
      n_checks++;
      if (n >= DB + 2 && n <= DB + 4) n_pass++;
      else $display("FAIL press_latency: got %0d cycles, required %0d..%0d", n, DB + 2, DB + 4);
      check("press_led", led, exp_led);
      sb_en = sb_after;
    end
    while (n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    btn_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Scoreboard monitor: every tick must be followed by the next queued pattern value, WT cycles apart.
  always @(negedge clk) begin : monitor
    exp_t e;
    tick_neg = tick;
    if (!sb_en) begin
      pend      = 1'b0;
      last_tick = -1;
    end else begin
      if (pend) begin
        if (sb_q.size() == 0) begin
          fail_now("sb_underflow");
        end else begin
          e = sb_q.pop_front();
          check("sb_led", led, e.led);
          check("sb_mode", mode, e.mode);
        end
        pend = 1'b0;
      end
      if (tick) begin
        if (last_tick >= 0) check("tick_period", cyc - last_tick, WT);
        last_tick = cyc;
        pend      = 1'b1;
      end
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n;
    int   k;
    int   m;
    bit   seen;
    bit   got;
    bit   changed;
    logic [NL-1:0] fill_seq [5];

    fill_seq[0] = 4'b1111;
    fill_seq[1] = 4'b1110;
    fill_seq[2] = 4'b1100;
    fill_seq[3] = 4'b1000;
    fill_seq[4] = 4'b0000;

    // Pause table: nine frozen cycles, then the held counter resumes and steps three edges later.
    for (int i = 0; i < 9; i++) vecs[i] = '{pause: 1'b1, btn_n: 1'b1, exp_led: 4'b0110, exp_mode: 2'd3, exp_tick: 1'b0};
    vecs[9]  = '{pause: 1'b0, btn_n: 1'b1, exp_led: 4'b0110, exp_mode: 2'd3, exp_tick: 1'b0};
    vecs[10] = '{pause: 1'b0, btn_n: 1'b1, exp_led: 4'b0110, exp_mode: 2'd3, exp_tick: 1'b1};
    vecs[11] = '{pause: 1'b0, btn_n: 1'b1, exp_led: 4'b0111, exp_mode: 2'd3, exp_tick: 1'b0};
    vecs[12] = '{pause: 1'b0, btn_n: 1'b1, exp_led: 4'b0111, exp_mode: 2'd3, exp_tick: 1'b0};

    // Reset state while clocks run.
    rst_n = 1'b0;
    btn_n = 1'b1;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", led, 4'b1111);
    check("reset_mode", mode, 2'd0);
    check("reset_tick", tick, 1'b0);

    // Release reset; the first fill step lands on the WT-th rising edge.
    rst_n = 1'b1;
    n = 0;
    changed = 1'b0;
    while (!changed && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      changed = (led != 4'b1111);
    end
    check("first_step_edges", n, WT);
    check("first_step_led", led, 4'b1110);

    // Idle fill for 19 more ticks.
    for (int i = 2; i <= 20; i++) push_exp(fill_seq[i % 5], 2'd0);
    sb_en = 1'b1;
    drain();
    sb_en = 1'b0;

    // Press into bounce.
    push_exp(4'b0010, 2'd1);
    push_exp(4'b0100, 2'd1);
    push_exp(4'b1000, 2'd1);
    push_exp(4'b0100, 2'd1);
    push_exp(4'b0010, 2'd1);
    push_exp(4'b0001, 2'd1);
    push_exp(4'b0010, 2'd1);
    @(negedge clk);
    do_press(2'd1, 4'b0001, 1'b1, lat);
    drain();
    sb_en = 1'b0;

    // Press into blink.
    push_exp(4'b0000, 2'd2);
    push_exp(4'b1111, 2'd2);
    push_exp(4'b0000, 2'd2);
    push_exp(4'b1111, 2'd2);
    @(negedge clk);
    do_press(2'd2, 4'b1111, 1'b1, lat);
    drain();
    sb_en = 1'b0;

    // Press into count, including the wrap from 1111 to 0000.
    for (int i = 1; i <= 15; i++) push_exp(4'(i), 2'd3);
    push_exp(4'b0000, 2'd3);
    push_exp(4'b0001, 2'd3);
    @(negedge clk);
    do_press(2'd3, 4'b0000, 1'b1, lat);
    drain();

    // Short glitches of 1 and 2 cycles must not disturb the count.
    for (int i = 2; i <= 6; i++) push_exp(4'(i), 2'd3);
    @(negedge clk);
    btn_n = 1'b0;
    @(negedge clk);
    btn_n = 1'b1;
    repeat (5) @(negedge clk);
    btn_n = 1'b0;
    repeat (2) @(negedge clk);
    btn_n = 1'b1;
    drain();
    sb_en = 1'b0;
    check("glitch_mode", mode, 2'd3);

    // Pause vectors.
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      pause = vecs[i].pause;
      btn_n = vecs[i].btn_n;
      @(negedge clk);
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
    end
    push_exp(4'b1000, 2'd3);
    push_exp(4'b1001, 2'd3);
    sb_en = 1'b1;
    drain();
    sb_en = 1'b0;

    // A press during pause still advances the mode (count -> fill).
    @(negedge clk);
    pause = 1'b1;
    do_press(2'd0, 4'b1111, 1'b0, lat);
    check("pause_press_led_held", led, 4'b1111);
    check("pause_press_tick", tick, 1'b0);
    check("pause_press_mode", mode, 2'd0);
    pause = 1'b0;

    // Time a press to land on a step edge: the press wins and the counter restarts.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = tick;
    end
    if (!got) fail_now("tick_wait");
    m = (WT - ((lat - 1) % WT)) % WT;
    repeat (m) @(negedge clk);
    btn_n = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = (mode == 2'd1);
    end
    if (!seen) begin
      fail_now("collide_mode_change");
    end else begin
      check("collide_tick_same_cycle", tick_neg, 1'b1);
      check("collide_led", led, 4'b0001);
      k = 0;
      changed = 1'b0;
      while (!changed && k < 12) begin
        @(posedge clk);
        #1;
        k++;
        changed = (led != 4'b0001);
      end
      check("collide_next_step_edges", k, WT);
      check("collide_next_led", led, 4'b0010);
    end
    @(negedge clk);
    btn_n = 1'b1;
    repeat (8) @(negedge clk);

    // Reset pulse mid-debounce and mid-pattern.
    btn_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", led, 4'b1111);
    check("async_reset_mode", mode, 2'd0);
    check("async_reset_tick", tick, 1'b0);
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hold_led", led, 4'b1111);
    rst_n = 1'b1;
    n = 0;
    changed = 1'b0;
    while (!changed && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      changed = (led != 4'b1111);
    end
    check("rerelease_first_step_edges", n, WT);
    check("rerelease_first_step_led", led, 4'b1110);
    push_exp(4'b1100, 2'd0);
    push_exp(4'b1000, 2'd0);
    push_exp(4'b0000, 2'd0);
    push_exp(4'b1111, 2'd0);
    sb_en = 1'b1;
    drain();
    sb_en = 1'b0;
    check("no_spurious_press_mode", mode, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
